// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM states and per-stage stall vectors.
// Stall bit order: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        FLUSH    = 2'd2
    } pipe_state_e;

    localparam logic [5:0] NO_STALL  = 6'b000000;
    localparam logic [5:0] STALL_IF  = 6'b000011;
    localparam logic [5:0] STALL_ID  = 6'b000111;
    localparam logic [5:0] STALL_EX  = 6'b001111;
    localparam logic [5:0] STALL_MEM = 6'b011111;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Event counter with selectable behaviour at all-ones: saturate (hold) or wrap to zero.
module sat_counter #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc) begin
            if (!(SATURATE && (r_count == '1))) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: priority stall generation, exception flush
// sequencing with a PC redirect, and stall/flush statistics.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned EXCP_ADDR_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stallreq_if,
    input  logic                   stallreq_id,
    input  logic                   stallreq_ex,
    input  logic                   stallreq_mem,
    input  logic                   excp_valid,
    input  logic [EXCP_ADDR_W-1:0] excp_target,
    output logic [5:0]             stall,
    output logic                   flush,
    output logic [EXCP_ADDR_W-1:0] new_pc,
    output logic                   new_pc_valid,
    output logic [31:0]            stall_cycles,
    output logic [15:0]            flush_count
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    pipe_state_e            r_state;
    pipe_state_e            w_next;
    logic [3:0]             r_fcnt;
    logic [EXCP_ADDR_W-1:0] r_target;
    logic [EXCP_ADDR_W-1:0] r_new_pc;
    logic                   r_first;
    logic                   w_enter;
    logic                   w_latch;
    logic [EXCP_ADDR_W-1:0] w_entry_target;
    logic [5:0]             w_stall_req;

    always_comb begin
        w_stall_req = NO_STALL;
        if (stallreq_mem)     w_stall_req = STALL_MEM;
        else if (stallreq_ex) w_stall_req = STALL_EX;
        else if (stallreq_id) w_stall_req = STALL_ID;
        else if (stallreq_if) w_stall_req = STALL_IF;
    end

    assign stall = (r_state == FLUSH) ? NO_STALL : w_stall_req;

    always_comb begin
        w_next  = r_state;
        w_enter = 1'b0;
        w_latch = 1'b0;
        unique case (r_state)
            RUN: begin
                if (excp_valid) begin
                    w_latch = 1'b1;
                    if (stallreq_mem) begin
                        w_next = WAIT_MEM;
                    end else begin
                        w_next  = FLUSH;
                        w_enter = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                if (!stallreq_mem) begin
                    w_next  = FLUSH;
                    w_enter = 1'b1;
                end
            end
            FLUSH: begin
                if (r_fcnt == 4'd0) w_next = RUN;
            end
            default: w_next = RUN;
        endcase
    end

    // Direct RUN->FLUSH entry must redirect to the target arriving this cycle,
    // since the latch register only updates on the same edge.
    assign w_entry_target = w_latch ? excp_target : r_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_fcnt   <= '0;
            r_target <= '0;
            r_new_pc <= '0;
            r_first  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch) r_target <= excp_target;
            if (w_enter) begin
                r_fcnt   <= FLUSH_LOAD;
                r_new_pc <= w_entry_target;
                r_first  <= 1'b1;
            end else begin
                r_first <= 1'b0;
                if ((r_state == FLUSH) && (r_fcnt != 4'd0)) r_fcnt <= r_fcnt - 4'd1;
            end
        end
    end

    assign flush        = (r_state == FLUSH);
    assign new_pc_valid = r_first;
    assign new_pc       = r_new_pc;

    sat_counter #(
        .WIDTH   (32),
        .SATURATE(1'b1)
    ) u_stall_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_inc  (stall != NO_STALL),
        .o_count(stall_cycles)
    );

    sat_counter #(
        .WIDTH   (16),
        .SATURATE(1'b0)
    ) u_flush_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_inc  (w_enter),
        .o_count(flush_count)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared each cycle against a behavioural model.
module tb_pipe_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sif = 1'b0, sid = 1'b0, sex = 1'b0, smem = 1'b0, ev = 1'b0;
    logic [31:0] et = '0;
    logic [5:0]  stall;
    logic        flush, new_pc_valid;
    logic [31:0] new_pc, stall_cycles;
    logic [15:0] flush_count;

    int errors = 0;
    int checks = 0;

    pipe_ctrl #(.FLUSH_CYCLES(FC), .EXCP_ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
        .excp_valid(ev), .excp_target(et),
        .stall(stall), .flush(flush), .new_pc(new_pc), .new_pc_valid(new_pc_valid),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: remaining flush cycles, pending wait for memory, counters.
    int          m_flush_left = 0;
    bit          m_waiting = 0;
    bit          m_first = 0;
    logic [31:0] m_tgt = '0;
    logic [31:0] m_newpc = '0;
    longint      m_sc = 0;
    int          m_fc = 0;

    function automatic logic [5:0] exp_stall();
        int depth;
        if (m_flush_left > 0) return 6'b0;
        depth = smem ? 5 : sex ? 4 : sid ? 3 : sif ? 2 : 0;
        return 6'((1 << depth) - 1);
    endfunction

    task automatic enter_flush();
        m_flush_left = FC;
        m_first      = 1;
        m_newpc      = m_tgt;
        m_fc         = (m_fc + 1) % 65536;
        m_waiting    = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flush_left = 0; m_waiting = 0; m_first = 0;
            m_tgt = '0; m_newpc = '0; m_sc = 0; m_fc = 0;
        end else begin
            if (exp_stall() != 6'b0 && m_sc < 64'hFFFF_FFFF) m_sc++;
            if (m_flush_left > 0) begin
                m_flush_left--;
                m_first = 0;
            end else if (m_waiting) begin
                if (!smem) enter_flush();
            end else if (ev) begin
                m_tgt = et;
                if (smem) m_waiting = 1;
                else enter_flush();
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("stall", 32'(stall), 32'(exp_stall()));
        chk("flush", 32'(flush), 32'(m_flush_left > 0));
        chk("new_pc_valid", 32'(new_pc_valid), 32'(m_first));
        chk("new_pc", new_pc, m_newpc);
        chk("stall_cycles", stall_cycles, m_sc[31:0]);
        chk("flush_count", 32'(flush_count), 32'(m_fc));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        sif = 0; sid = 0; sex = 0; smem = 0; ev = 0;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_stall_cycles", stall_cycles, 32'h0);
        chk("rst_flush_count", 32'(flush_count), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_new_pc", new_pc, 32'h0);

        // load-use plus icache miss together
        step(); sid = 1; sif = 1; #1;
        chk("id_if_stall", 32'(stall), 32'h07);
        step(); idle(); #1;
        chk("id_if_stall_cycles", stall_cycles, 32'd1);

        // exception straight from RUN
        ev = 1; et = 32'h8000_0180;
        step(); ev = 0; #1;
        chk("excp_flush0", 32'(flush), 32'h1);
        chk("excp_npv0", 32'(new_pc_valid), 32'h1);
        chk("excp_newpc0", new_pc, 32'h8000_0180);
        step(); #1;
        chk("excp_flush1", 32'(flush), 32'h1);
        chk("excp_npv1", 32'(new_pc_valid), 32'h0);
        step(); #1;
        chk("excp_run", 32'(flush), 32'h0);
        chk("excp_fcount", 32'(flush_count), 32'd1);

        // exception waiting on outstanding MEM
        ev = 1; smem = 1; et = 32'h0000_1234;
        step(); ev = 0; #1;
        chk("wait_stall1", 32'(stall), 32'h1F);
        chk("wait_noflush1", 32'(flush), 32'h0);
        step(); #1;
        chk("wait_stall2", 32'(stall), 32'h1F);
        step(); smem = 0; #1;
        chk("wait_noflush3", 32'(flush), 32'h0);
        step(); #1;
        chk("wait_flush", 32'(flush), 32'h1);
        chk("wait_newpc", new_pc, 32'h0000_1234);
        step(); step(); #1;
        chk("wait_done", 32'(flush), 32'h0);

        // second exception during FLUSH is ignored; back-to-back after flush accepted
        ev = 1; et = 32'h0000_0A00;
        step(); et = 32'h0000_DEAD; #1;
        step(); ev = 0; #1;
        chk("ign_newpc", new_pc, 32'h0000_0A00);
        chk("ign_flush", 32'(flush), 32'h1);
        step(); #1;
        chk("ign_run", 32'(flush), 32'h0);
        chk("ign_fcount", 32'(flush_count), 32'd3);
        ev = 1; et = 32'h0000_0B00;
        step(); ev = 0; #1;
        chk("b2b_newpc", new_pc, 32'h0000_0B00);
        chk("b2b_npv", 32'(new_pc_valid), 32'h1);
        step(); step(); #1;

        // async reset in first FLUSH cycle
        ev = 1; et = 32'h0000_0C00;
        step(); ev = 0; #1;
        rst_n = 0; #1;
        chk("rst_async_flush", 32'(flush), 32'h0);
        chk("rst_async_npv", 32'(new_pc_valid), 32'h0);
        @(negedge clk); #1 rst_n = 1;
        chk("rst_rel_sc", stall_cycles, 32'h0);
        chk("rst_rel_fc", 32'(flush_count), 32'h0);
        step(); step(); #1;
        chk("rst_rel_noflush", 32'(flush), 32'h0);

        // stall counter saturation
        @(negedge clk); #1;
        force dut.u_stall_cnt.r_count = 32'hFFFF_FFFE;
        m_sc = 64'hFFFF_FFFE;
        #1 release dut.u_stall_cnt.r_count;
        step(); sex = 1;
        step(); step(); step(); sex = 0; #1;
        chk("sat_value", stall_cycles, 32'hFFFF_FFFF);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step();
            sif  = ($urandom_range(0, 3) == 0);
            sid  = ($urandom_range(0, 5) == 0);
            sex  = ($urandom_range(0, 7) == 0);
            smem = ($urandom_range(0, 3) == 0);
            ev   = ($urandom_range(0, 5) == 0);
            et   = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 0;
                #2 rst_n = 1;
            end
        end
        step(); idle();
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
